ws2812_frame_arbiter: RTL and testbench

- Shares one WS2812 serial output block between several pattern generators, such as the fader and a test/static pattern source.
- Grants the strip to one source for a whole frame, streams that source's bytes to the output block on its per-byte data requests, and waits for the output block to finish.
- Enforces the WS2812 latch gap before the next frame starts.
- Sits between the pattern sources and the output block, replacing the direct trigger/data_request wiring.

---
 rtl/ws2812_pkg.sv | 15 +
 rtl/ws2812_frame_arbiter_if.sv | 31 +++
 rtl/ws2812_frame_arbiter_rr_arbiter.sv | 41 ++++
 rtl/ws2812_frame_arbiter.sv | 124 ++++++++++++
 tb/tb_ws2812_frame_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and FSM state type for the WS2812 frame arbiter slice.
package ws2812_pkg;

  localparam int BYTES_PER_LED        = 3;
  localparam int DEFAULT_LATCH_CYCLES = 1200;

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    START,
    STREAM,
    DRAIN
  } arb_state_e;

endpackage

// File: rtl/ws2812_frame_arbiter_if.sv
// Bundle between the pattern sources, the frame arbiter and the WS2812 output block.
interface ws2812_frame_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic [NUM_SRC-1:0]   src_req;
  logic [NUM_SRC*8-1:0] src_data;
  logic [NUM_SRC-1:0]   src_grant;
  logic [NUM_SRC-1:0]   src_ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_data_request;
  logic                 tx_done;
  logic                 frame_done;
  logic [IDW-1:0]       active_src;
  logic                 busy;

  // The arbiter side.
  modport slave (
    input  src_req, src_data, tx_data_request, tx_done,
    output src_grant, src_ack, tx_start, tx_data, frame_done, active_src, busy
  );

  // The environment side: pattern sources plus the output block.
  modport master (
    output src_req, src_data, tx_data_request, tx_done,
    input  src_grant, src_ack, tx_start, tx_data, frame_done, active_src, busy
  );

endinterface

// File: rtl/ws2812_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward with wrap.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  rot_idx;
  logic           hit;
  logic [IW:0]    sum;

  assign start   = (last_grant_i >= IW'(N-1)) ? '0 : last_grant_i + 1'b1;
  assign req_dbl = {req_i, req_i};
  // Rotate so that position 0 is the highest-priority candidate.
  assign req_rot = req_dbl[start +: N];

  always_comb begin
    rot_idx = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req_rot[k]) begin
        hit     = 1'b1;
        rot_idx = IW'(k);
      end
    end
  end

  assign sum     = {1'b0, start} + {1'b0, rot_idx};
  assign idx_o   = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
  assign grant_o = hit ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Grants one WS2812 output block to one pattern source per frame, then enforces the latch gap.
module ws2812_frame_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int LEDS         = 32,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int IDW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ws2812_frame_arbiter_if.slave bus
);

  localparam int FRAME_BYTES = LEDS * BYTES_PER_LED;
  localparam int BW          = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int GW          = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BYTE  = BW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(LATCH_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [BW-1:0]      byte_q, byte_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDW-1:0]     active_q, active_d;
  logic [IDW-1:0]     last_q, last_d;
  logic               tx_start_q, tx_start_d;
  logic               frame_done_q, frame_done_d;

  logic [NUM_SRC-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic [7:0]         src_byte [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_byte
    assign src_byte[gi] = bus.src_data[8*gi +: 8];
  end

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (IDW)
  ) u_rr (
    .req_i        (bus.src_req),
    .last_grant_i (last_q),
    .grant_o      (arb_grant),
    .idx_o        (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GAP;
      gap_q        <= GAP_RELOAD;
      byte_q       <= '0;
      grant_q      <= '0;
      active_q     <= '0;
      last_q       <= IDW'(NUM_SRC - 1);
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      byte_q       <= byte_d;
      grant_q      <= grant_d;
      active_q     <= active_d;
      last_q       <= last_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    byte_d       = byte_q;
    grant_d      = grant_q;
    active_d     = active_q;
    last_d       = last_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      IDLE: begin
        if (bus.src_req != '0) begin
          grant_d  = arb_grant;
          active_d = arb_idx;
          last_d   = arb_idx;
          state_d  = START;
        end
      end
      START: begin
        // tx_start is registered, so it lands one edge after the grant.
        tx_start_d = 1'b1;
        byte_d     = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (bus.tx_data_request) begin
          if (byte_q == LAST_BYTE) state_d = DRAIN;
          else                     byte_d  = byte_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.tx_done) begin
          grant_d      = '0;
          frame_done_d = 1'b1;
          gap_d        = GAP_RELOAD;
          state_d      = GAP;
        end
      end
      default: state_d = GAP;
    endcase
  end

  assign bus.src_grant  = grant_q;
  assign bus.active_src = active_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.src_ack    = (state_q == STREAM && bus.tx_data_request) ? grant_q : '0;
  assign bus.tx_data    = (grant_q != '0) ? src_byte[active_q] : 8'h00;

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Self-checking bench for ws2812_frame_arbiter: table-driven frames, randomized frames, reset mid-stream.
module tb_ws2812_frame_arbiter;
  import ws2812_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int IDW     = 1;
  localparam int LEDS    = 4;
  localparam int LATCH   = DEFAULT_LATCH_CYCLES;
  localparam int FB      = LEDS * BYTES_PER_LED;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ws2812_frame_arbiter_if #(.NUM_SRC(NUM_SRC), .IDW(IDW)) bus_if ();

  ws2812_frame_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .LEDS         (LEDS),
    .LATCH_CYCLES (LATCH),
    .IDW          (IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [1:0] req;
    int         drop_after;
    int         exp_src;
  } frame_vec_t;

  frame_vec_t vecs [10];
  int n_tests = 0;
  int n_fail  = 0;
  int model_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int s);
    return 2'(1 << s);
  endfunction

  // Round-robin reference: first requester after the previous winner, with wrap.
  function automatic int model_pick(input logic [1:0] req, input int last);
    for (int k = 1; k <= NUM_SRC; k++) begin
      int c;
      c = (last + k) % NUM_SRC;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Called at the first cycle of GAP; expects the grant exactly LATCH+1 edges later.
  task automatic wait_grant(input logic [1:0] req, input int exp_src);
    int  waited;
    bit  ok;
    waited = 0;
    ok     = 1'b0;
    bus_if.src_req = req;
    while (waited < 3000) begin
      tick();
      waited++;
      if (bus_if.src_grant != '0) begin
        ok = 1'b1;
        break;
      end
      if (waited == 1) check("frame_done_one_cycle", bus_if.frame_done, 0);
      bus_if.tx_data_request = ($urandom_range(0, 3) == 0);
      bus_if.tx_done         = ($urandom_range(0, 7) == 0);
      bus_if.src_data        = 16'($urandom);
      #1;
      check("gap_ack", bus_if.src_ack, 0);
      check("gap_tx_data", bus_if.tx_data, 0);
    end
    bus_if.tx_data_request = 1'b0;
    bus_if.tx_done         = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: no grant after %0d cycles, expected %0d", waited, LATCH + 1);
    end else begin
      check("grant_latency", waited, LATCH + 1);
      check("grant", bus_if.src_grant, oh(exp_src));
      check("active_src", bus_if.active_src, exp_src);
      check("busy_start", bus_if.busy, 1);
      check("tx_start_early", bus_if.tx_start, 0);
      tick();
      check("tx_start", bus_if.tx_start, 1);
    end
  endtask

  task automatic stream(input int exp_src, input int nbytes, input int drop_after);
    logic [15:0] data;
    int          idle;
    for (int n = 0; n < nbytes; n++) begin
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        bus_if.tx_done = $urandom_range(0, 1) == 1;
        #1;
        check("stream_idle_ack", bus_if.src_ack, 0);
        tick();
      end
      bus_if.tx_done = 1'b0;
      if (n == drop_after) bus_if.src_req[exp_src] = 1'b0;
      data = 16'($urandom);
      bus_if.src_data        = data;
      bus_if.tx_data_request = 1'b1;
      #1;
      check("byte_ack", bus_if.src_ack, oh(exp_src));
      check("byte_tx_data", bus_if.tx_data, data[8*exp_src +: 8]);
      tick();
      bus_if.tx_data_request = 1'b0;
      if (n == 0) check("tx_start_once", bus_if.tx_start, 0);
    end
  endtask

  task automatic drain(input int exp_src);
    bus_if.tx_data_request = 1'b1;
    #1;
    check("drain_no_ack", bus_if.src_ack, 0);
    tick();
    bus_if.tx_data_request = 1'b0;
    repeat ($urandom_range(1, 5)) tick();
    check("drain_grant_held", bus_if.src_grant, oh(exp_src));
    check("drain_no_frame_done", bus_if.frame_done, 0);
    bus_if.tx_done = 1'b1;
    tick();
    bus_if.tx_done = 1'b0;
    check("frame_done", bus_if.frame_done, 1);
    check("release_grant", bus_if.src_grant, 0);
    check("release_busy", bus_if.busy, 1);
    check("release_tx_data", bus_if.tx_data, 0);
  endtask

  task automatic do_frame(input logic [1:0] req, input int drop_after, input int exp_src);
    wait_grant(req, exp_src);
    stream(exp_src, FB, drop_after);
    drain(exp_src);
    model_last = exp_src;
    $display("[TB] frame req=%b src=%0d drop_after=%0d", req, exp_src, drop_after);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rreq;
    int         rexp;
    int         rdrop;

    vecs[0] = '{req: 2'b01, drop_after: -1, exp_src: 0};
    vecs[1] = '{req: 2'b11, drop_after: -1, exp_src: 1};
    vecs[2] = '{req: 2'b11, drop_after: -1, exp_src: 0};
    vecs[3] = '{req: 2'b11, drop_after: -1, exp_src: 1};
    vecs[4] = '{req: 2'b11, drop_after: -1, exp_src: 0};
    vecs[5] = '{req: 2'b11, drop_after:  3, exp_src: 1};
    vecs[6] = '{req: 2'b11, drop_after: -1, exp_src: 0};
    vecs[7] = '{req: 2'b10, drop_after: -1, exp_src: 1};
    vecs[8] = '{req: 2'b10, drop_after: -1, exp_src: 1};
    vecs[9] = '{req: 2'b01, drop_after: -1, exp_src: 0};

    bus_if.src_req         = '0;
    bus_if.src_data        = '0;
    bus_if.tx_data_request = 1'b0;
    bus_if.tx_done         = 1'b0;
    model_last             = NUM_SRC - 1;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_grant", bus_if.src_grant, 0);
    check("rst_ack", bus_if.src_ack, 0);
    check("rst_tx_start", bus_if.tx_start, 0);
    check("rst_tx_data", bus_if.tx_data, 0);
    check("rst_frame_done", bus_if.frame_done, 0);
    check("rst_active_src", bus_if.active_src, 0);
    check("rst_busy", bus_if.busy, 1);

    foreach (vecs[i]) do_frame(vecs[i].req, vecs[i].drop_after, vecs[i].exp_src);

    for (int r = 0; r < 4; r++) begin
      rreq  = 2'($urandom_range(1, 3));
      rexp  = model_pick(rreq, model_last);
      rdrop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FB - 1)) : -1;
      do_frame(rreq, rdrop, rexp);
    end

    // Reset in the middle of a frame: the partial frame is abandoned.
    rexp = model_pick(2'b11, model_last);
    wait_grant(2'b11, rexp);
    stream(rexp, 5, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.tx_data_request = 1'b1;
    #1;
    check("midrst_grant", bus_if.src_grant, 0);
    check("midrst_tx_data", bus_if.tx_data, 0);
    check("midrst_busy", bus_if.busy, 1);
    check("midrst_ack", bus_if.src_ack, 0);
    check("midrst_tx_start", bus_if.tx_start, 0);
    check("midrst_active_src", bus_if.active_src, 0);
    bus_if.tx_data_request = 1'b0;
    model_last = NUM_SRC - 1;
    do_frame(2'b11, -1, model_pick(2'b11, model_last));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
